// File: rtl/posit_weight_serializer_if.sv
// ---------------------------------------------------------------------------
// posit_weight_serializer_if
// Input word handshake for posit_weight_serializer: a posit weight word and
// its paired FP16 activation, transferred on in_valid && in_ready.
//   in_valid  producer -> serializer   word/activation valid
//   in_ready  serializer -> producer   buffer can accept a word this cycle
//   in_word   producer -> serializer   posit weight, right-aligned
//   in_act    producer -> serializer   activation paired with in_word
// Modports: master = word producer, slave = serializer.
// ---------------------------------------------------------------------------
interface posit_weight_serializer_if #(
  parameter int ACT_WIDTH = 16,
  parameter int MAX_PREC  = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MAX_PREC-1:0]  in_word;
  logic [ACT_WIDTH-1:0] in_act;

  modport master (output in_valid, output in_word, output in_act, input in_ready);
  modport slave  (input in_valid, input in_word, input in_act, output in_ready);
endinterface

// File: rtl/posit_weight_serializer.sv
// ---------------------------------------------------------------------------
// posit_weight_serializer
// Buffers posit weight words (with their FP16 activations) in a small FIFO,
// programs the downstream bit-serial multiplier's precision with a one-cycle
// set strobe, then streams each weight MSB-first on w/valid while act holds
// the paired activation for every bit of the word.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   cfg_set           request to load cfg_precision
//   cfg_precision     requested posit width (legal: 2..MAX_PREC)
//   cfg_err           one-cycle pulse: configuration request rejected
//   in_bus            word handshake (posit_weight_serializer_if.slave)
//   act               activation for the word being streamed
//   w, valid          serial weight bit and its qualifier
//   set, precision    precision-load strobe and value to the multiplier
//   busy              shifting, or buffer non-empty
//   skip_zero         zero-weight skip pulse
//
// Optional feature: define SER_ZERO_SKIP_EN to replace the serialization of
// an all-zero word (posit zero) by a single skip_zero pulse. Without it,
// zero words are streamed like any other and skip_zero stays 0.
// ---------------------------------------------------------------------------
module posit_weight_serializer #(
  parameter int ACT_WIDTH  = 16,
  parameter int MAX_PREC   = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_set,
  input  logic [3:0]              cfg_precision,
  output logic                    cfg_err,
  posit_weight_serializer_if.slave in_bus,
  output logic [ACT_WIDTH-1:0]    act,
  output logic                    w,
  output logic                    valid,
  output logic                    set,
  output logic [3:0]              precision,
  output logic                    busy,
  output logic                    skip_zero
);

  localparam int             AW         = $clog2(FIFO_DEPTH);
  localparam int             EW         = ACT_WIDTH + MAX_PREC;
  localparam logic [AW:0]    FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]     MAX_PREC_C = 4'(MAX_PREC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_SHIFT  = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [3:0]            prec_r;
  logic [EW-1:0]         mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [AW:0]           count_r, count_nxt_s;
  logic [MAX_PREC-1:0]   shift_r;
  logic [ACT_WIDTH-1:0]  act_sh_r;
  logic [3:0]            cnt_r;
  logic [ACT_WIDTH-1:0]  act_r;
  logic                  w_r, valid_r, set_r, cfg_err_r, skip_zero_r, busy_r;
  logic [3:0]            precision_r;

  logic                  in_ready_s, push_s, pop_s, emit_s, skip_s, last_s;
  logic                  cfg_accept_s, cfg_reject_s, cfg_legal_s, fifo_empty_s;
  logic [EW-1:0]         head_s;

  // Every in_ready term is a register except rst, which blocks pushes during reset.
  assign in_ready_s   = (count_r != FULL_CNT) && (prec_r != 4'd0) &&
                        (state_r != ST_CONFIG) && !rst;
  assign push_s       = in_bus.in_valid && in_ready_s;
  assign fifo_empty_s = (count_r == {(AW+1){1'b0}});
  assign cfg_legal_s  = (cfg_precision >= 4'd2) && (cfg_precision <= MAX_PREC_C);
  assign head_s       = mem_r[rd_ptr_r];

  assign in_bus.in_ready = in_ready_s;
  assign act             = act_r;
  assign w               = w_r;
  assign valid           = valid_r;
  assign set             = set_r;
  assign precision       = precision_r;
  assign cfg_err         = cfg_err_r;
  assign skip_zero       = skip_zero_r;
  assign busy            = busy_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control decode. The last bit of a word pops the next
  // buffered word straight into the shifter so words stream without a bubble.
  always_comb begin
    state_nxt_s  = state_r;
    pop_s        = 1'b0;
    emit_s       = 1'b0;
    skip_s       = 1'b0;
    last_s       = 1'b0;
    cfg_accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_set && fifo_empty_s && cfg_legal_s) begin
          state_nxt_s  = ST_CONFIG;
          cfg_accept_s = 1'b1;
        end else if (!fifo_empty_s) begin
          state_nxt_s = ST_SHIFT;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CONFIG: begin
        state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
`ifdef SER_ZERO_SKIP_EN
        // Left-aligned shifter is all zero only if the masked word was zero.
        if ((cnt_r == 4'd0) && (shift_r == {MAX_PREC{1'b0}})) begin
          skip_s = 1'b1;
          last_s = 1'b1;
        end else begin
          emit_s = 1'b1;
          last_s = (cnt_r == (prec_r - 4'd1));
        end
`else
        emit_s = 1'b1;
        last_s = (cnt_r == (prec_r - 4'd1));
`endif
        if (last_s) begin
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    cfg_reject_s = cfg_set && !cfg_accept_s;
    count_nxt_s  = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
  end

  // Input buffer: storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_bus.in_act, in_bus.in_word};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_nxt_s;
    end
  end

  // Shifter, serial outputs, configuration outputs and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      prec_r      <= 4'd0;
      shift_r     <= {MAX_PREC{1'b0}};
      act_sh_r    <= {ACT_WIDTH{1'b0}};
      cnt_r       <= 4'd0;
      act_r       <= {ACT_WIDTH{1'b0}};
      w_r         <= 1'b0;
      valid_r     <= 1'b0;
      set_r       <= 1'b0;
      precision_r <= 4'd0;
      cfg_err_r   <= 1'b0;
      skip_zero_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (cfg_accept_s) begin
        prec_r <= cfg_precision;
      end else begin
        prec_r <= prec_r;
      end
      // Left-align the word so its sign bit sits at the shifter MSB; bits
      // above prec_r-1 fall off the top.
      if (pop_s) begin
        shift_r  <= head_s[MAX_PREC-1:0] << (MAX_PREC_C - prec_r);
        act_sh_r <= head_s[EW-1:MAX_PREC];
        cnt_r    <= 4'd0;
      end else if (emit_s) begin
        shift_r  <= shift_r << 1;
        act_sh_r <= act_sh_r;
        cnt_r    <= cnt_r + 4'd1;
      end else begin
        shift_r  <= shift_r;
        act_sh_r <= act_sh_r;
        cnt_r    <= cnt_r;
      end
      if (emit_s) begin
        w_r <= shift_r[MAX_PREC-1];
      end else begin
        w_r <= 1'b0;
      end
      // act only moves with a word's first bit, so the previous word's
      // last bit still sees its own activation.
      if (emit_s && (cnt_r == 4'd0)) begin
        act_r <= act_sh_r;
      end else begin
        act_r <= act_r;
      end
      valid_r     <= emit_s;
      skip_zero_r <= skip_s;
      set_r       <= cfg_accept_s;
      precision_r <= cfg_accept_s ? cfg_precision : 4'd0;
      cfg_err_r   <= cfg_reject_s;
      busy_r      <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {(AW+1){1'b0}});
    end
  end

endmodule

// File: tb/tb_posit_weight_serializer.sv
// ---------------------------------------------------------------------------
// tb_posit_weight_serializer
// Self-checking bench for posit_weight_serializer. A queue-based source
// drives the word handshake; accepted words are expanded into the expected
// bit stream by a reference model (integer arithmetic on the masked word);
// the observed stream is collected every cycle and compared per scenario.
// ---------------------------------------------------------------------------
module tb_posit_weight_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_set = 1'b0;
  logic [3:0]  cfg_precision = 4'd0;
  logic        cfg_err, w, valid, set, busy, skip_zero;
  logic [15:0] act;
  logic [3:0]  precision;

  posit_weight_serializer_if #(.ACT_WIDTH(16), .MAX_PREC(8)) in_if ();

  posit_weight_serializer #(.ACT_WIDTH(16), .MAX_PREC(8), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .cfg_set(cfg_set), .cfg_precision(cfg_precision),
    .cfg_err(cfg_err), .in_bus(in_if), .act(act), .w(w), .valid(valid),
    .set(set), .precision(precision), .busy(busy), .skip_zero(skip_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_prec = 0;
  int gap_pct = 0;

  logic [7:0]  src_word[$];
  logic [15:0] src_act[$];
  bit          exp_bit[$];
  logic [15:0] exp_act[$];
  bit          exp_first[$];
  int          exp_skips;
  bit          obs_bit[$];
  logic [15:0] obs_act[$];
  int          obs_cyc[$];
  int          obs_skips;
  int          skip_with_valid;
  bit          saw_not_ready;

  // Reference model: the masked word, sign bit first, prec bits per word.
  task automatic model_accept(input logic [7:0] word, input logic [15:0] a);
    int v;
    v = int'(word) % (1 << model_prec);
`ifdef SER_ZERO_SKIP_EN
    if (v == 0) begin
      exp_skips++;
      return;
    end
`endif
    for (int k = 0; k < model_prec; k++) begin
      exp_bit.push_back(((v >> (model_prec - 1 - k)) & 1) != 0);
      exp_act.push_back(a);
      exp_first.push_back(k == 0);
    end
  endtask

  // One clock: retire an accepted word, record outputs, present the next word.
  task automatic tick();
    logic acc;
    acc = in_if.in_valid && in_if.in_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      model_accept(src_word[0], src_act[0]);
      void'(src_word.pop_front());
      void'(src_act.pop_front());
    end
    if (valid) begin
      obs_bit.push_back(w);
      obs_act.push_back(act);
      obs_cyc.push_back(cyc);
    end
    if (skip_zero) begin
      obs_skips++;
      if (valid) skip_with_valid++;
    end
    if (!in_if.in_ready && !rst) saw_not_ready = 1'b1;
    if (src_word.size() > 0 && ($urandom_range(99) >= gap_pct)) begin
      in_if.in_valid = 1'b1;
      in_if.in_word  = src_word[0];
      in_if.in_act   = src_act[0];
    end else begin
      in_if.in_valid = 1'b0;
      in_if.in_word  = 8'($urandom_range(255));
      in_if.in_act   = 16'($urandom_range(65535));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_obs();
    exp_bit.delete(); exp_act.delete(); exp_first.delete();
    obs_bit.delete(); obs_act.delete(); obs_cyc.delete();
    exp_skips = 0; obs_skips = 0; skip_with_valid = 0; saw_not_ready = 1'b0;
  endtask

  task automatic configure(input int p);
    cfg_set = 1'b1;
    cfg_precision = 4'(p);
    tick();
    cfg_set = 1'b0;
    tick();
    if (p >= 2 && p <= 8) model_prec = p;
    saw_not_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_if.in_valid = 1'b0; in_if.in_word = 8'h00; in_if.in_act = 16'h0000;
    run(2);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL reset_w got %0b want 0", w); end
    checks++; if (set !== 1'b0) begin errors++; $display("FAIL reset_set got %0b want 0", set); end
    checks++; if (precision !== 4'd0) begin errors++; $display("FAIL reset_precision got %0d want 0", precision); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %0b want 0", cfg_err); end
    checks++; if (skip_zero !== 1'b0) begin errors++; $display("FAIL reset_skip got %0b want 0", skip_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (act !== 16'h0000) begin errors++; $display("FAIL reset_act got %h want 0000", act); end
    checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_if.in_ready); end
    rst = 1'b0;
    model_prec = 0;
    tick();
    checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL unconfigured_in_ready got %0b want 0", in_if.in_ready); end
  endtask

  task automatic test_config();
    cfg_set = 1'b1;
    cfg_precision = 4'd6;
    tick();
    cfg_set = 1'b0;
    checks++; if (set !== 1'b1) begin errors++; $display("FAIL config_set got %0b want 1", set); end
    checks++; if (precision !== 4'd6) begin errors++; $display("FAIL config_precision got %0d want 6", precision); end
    checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL config_in_ready got %0b want 0", in_if.in_ready); end
    tick();
    model_prec = 6;
    checks++; if (set !== 1'b0) begin errors++; $display("FAIL config_set_len got %0b want 0", set); end
    checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL config_ready_after got %0b want 1", in_if.in_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL config_no_err got %0b want 0", cfg_err); end
  endtask

  task automatic test_illegal_cfg();
    int bad[2];
    bad[0] = 1; bad[1] = 9;
    for (int i = 0; i < 2; i++) begin
      cfg_set = 1'b1;
      cfg_precision = 4'(bad[i]);
      tick();
      cfg_set = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_err p=%0d got %0b want 1", bad[i], cfg_err); end
      checks++; if (set !== 1'b0) begin errors++; $display("FAIL illegal_set p=%0d got %0b want 0", bad[i], set); end
      tick();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_err_len p=%0d got %0b want 0", bad[i], cfg_err); end
    end
  endtask

  task automatic test_single_word();
    int start;
    clear_obs();
    gap_pct = 0;
    src_word.push_back(8'hED);  // low 6 bits 101101, upper bits must be ignored
    src_act.push_back(16'h3C00);
    tick();
    start = cyc;
    run(12);
    checks++; if (obs_bit.size() != 6) begin errors++; $display("FAIL single_count got %0d want 6", obs_bit.size()); end
    for (int i = 0; i < exp_bit.size() && i < obs_bit.size(); i++) begin
      checks++; if (obs_bit[i] !== exp_bit[i]) begin errors++; $display("FAIL single_bit[%0d] got %0b want %0b", i, obs_bit[i], exp_bit[i]); end
      checks++; if (obs_act[i] !== 16'h3C00) begin errors++; $display("FAIL single_act[%0d] got %h want 3c00", i, obs_act[i]); end
    end
    if (obs_cyc.size() == 6) begin
      checks++; if (obs_cyc[0] != start + 3) begin errors++; $display("FAIL single_latency got %0d want %0d", obs_cyc[0] - start - 1, 2); end
      checks++; if (obs_cyc[5] - obs_cyc[0] != 5) begin errors++; $display("FAIL single_contig span got %0d want 5", obs_cyc[5] - obs_cyc[0]); end
    end
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end valid=%0b busy=%0b want 0 0", valid, busy); end
  endtask

  task automatic test_back_to_back();
    configure(4);
    clear_obs();
    gap_pct = 0;
    src_word.push_back(8'h5A); src_act.push_back(16'h1111);
    src_word.push_back(8'hC3); src_act.push_back(16'h2222);
    src_word.push_back(8'h0F); src_act.push_back(16'h3333);
    run(25);
    checks++; if (obs_bit.size() != 12) begin errors++; $display("FAIL b2b_count got %0d want 12", obs_bit.size()); end
    for (int i = 0; i < exp_bit.size() && i < obs_bit.size(); i++) begin
      checks++; if (obs_bit[i] !== exp_bit[i]) begin errors++; $display("FAIL b2b_bit[%0d] got %0b want %0b", i, obs_bit[i], exp_bit[i]); end
      checks++; if (obs_act[i] !== exp_act[i]) begin errors++; $display("FAIL b2b_act[%0d] got %h want %h", i, obs_act[i], exp_act[i]); end
    end
    if (obs_cyc.size() == 12) begin
      checks++; if (obs_cyc[11] - obs_cyc[0] != 11) begin errors++; $display("FAIL b2b_contig span got %0d want 11", obs_cyc[11] - obs_cyc[0]); end
    end
    checks++; if (saw_not_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_drop got %0b want 1", saw_not_ready); end
  endtask

  task automatic test_busy_cfg_reset();
    int n;
    configure(6);
    clear_obs();
    gap_pct = 0;
    src_word.push_back(8'h2B); src_act.push_back(16'h4444);
    src_word.push_back(8'h15); src_act.push_back(16'h5555);
    n = 0;
    while (obs_bit.size() < 1 && n < 30) begin tick(); n++; end
    checks++; if (obs_bit.size() != 1) begin errors++; $display("FAIL busycfg_start bits=%0d want 1", obs_bit.size()); end
    cfg_set = 1'b1;
    cfg_precision = 4'd4;
    tick();
    cfg_set = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL busycfg_err got %0b want 1", cfg_err); end
    checks++; if (set !== 1'b0) begin errors++; $display("FAIL busycfg_set got %0b want 0", set); end
    n = 0;
    while (obs_bit.size() < 3 && n < 30) begin tick(); n++; end
    checks++; if (obs_bit.size() != 3) begin errors++; $display("FAIL busycfg_third bits=%0d want 3", obs_bit.size()); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL busycfg_err_len got %0b want 0", cfg_err); end
    for (int i = 0; i < 3 && i < obs_bit.size(); i++) begin
      checks++; if (obs_bit[i] !== exp_bit[i]) begin errors++; $display("FAIL busycfg_bit[%0d] got %0b want %0b", i, obs_bit[i], exp_bit[i]); end
    end
    rst = 1'b1;
    src_word.delete(); src_act.delete();
    in_if.in_valid = 1'b0;
    tick();
    model_prec = 0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
    checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %0b want 0", in_if.in_ready); end
    rst = 1'b0;
    run(10);
    checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL midreset_unconf_ready got %0b want 0", in_if.in_ready); end
    checks++; if (obs_bit.size() != 3) begin errors++; $display("FAIL midreset_no_more_bits got %0d want 3", obs_bit.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_after got %0b want 0", busy); end
  endtask

  task automatic test_zero_skip();
    int want_bits;
    int want_skips;
`ifdef SER_ZERO_SKIP_EN
    want_bits = 5; want_skips = 1;
`else
    want_bits = 10; want_skips = 0;
`endif
    configure(5);
    clear_obs();
    gap_pct = 0;
    src_word.push_back(8'hE0); src_act.push_back(16'h0101);  // low 5 bits zero
    src_word.push_back(8'h11); src_act.push_back(16'h0202);
    run(25);
    checks++; if (obs_bit.size() != want_bits) begin errors++; $display("FAIL zero_count got %0d want %0d", obs_bit.size(), want_bits); end
    checks++; if (obs_skips != want_skips) begin errors++; $display("FAIL zero_skips got %0d want %0d", obs_skips, want_skips); end
    checks++; if (skip_with_valid != 0) begin errors++; $display("FAIL zero_skip_valid got %0d want 0", skip_with_valid); end
    for (int i = 0; i < exp_bit.size() && i < obs_bit.size(); i++) begin
      checks++; if (obs_bit[i] !== exp_bit[i]) begin errors++; $display("FAIL zero_bit[%0d] got %0b want %0b", i, obs_bit[i], exp_bit[i]); end
    end
  endtask

  task automatic test_random();
    int p, nw, n;
    logic [7:0] wd;
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(8, 2);
      configure(p);
      clear_obs();
      gap_pct = $urandom_range(50);
      nw = $urandom_range(10, 3);
      for (int j = 0; j < nw; j++) begin
        wd = 8'($urandom_range(255));
        if ($urandom_range(4) == 0) wd = wd & ~8'((1 << p) - 1);
        src_word.push_back(wd);
        src_act.push_back(16'($urandom_range(65535)));
      end
      n = 0;
      while ((src_word.size() > 0 || busy || valid || in_if.in_valid) && n < 600) begin tick(); n++; end
      run(3);
      checks++; if (n >= 600) begin errors++; $display("FAIL rand%0d_timeout cycles=%0d limit 600", r, n); end
      checks++; if (obs_bit.size() != exp_bit.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, obs_bit.size(), exp_bit.size()); end
      checks++; if (obs_skips != exp_skips) begin errors++; $display("FAIL rand%0d_skips got %0d want %0d", r, obs_skips, exp_skips); end
      for (int i = 0; i < exp_bit.size() && i < obs_bit.size(); i++) begin
        checks++;
        if (obs_bit[i] !== exp_bit[i] || obs_act[i] !== exp_act[i]) begin
          errors++;
          $display("FAIL rand%0d_bit[%0d] got w=%0b act=%h want w=%0b act=%h", r, i, obs_bit[i], obs_act[i], exp_bit[i], exp_act[i]);
        end
        if (i > 0 && !exp_first[i]) begin
          checks++; if (obs_cyc[i] != obs_cyc[i-1] + 1) begin errors++; $display("FAIL rand%0d_gap[%0d] got %0d want 1", r, i, obs_cyc[i] - obs_cyc[i-1]); end
        end
      end
    end
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_word  = 8'h00;
    in_if.in_act   = 16'h0000;
    test_reset();
    test_config();
    test_illegal_cfg();
    test_single_word();
    test_back_to_back();
    test_busy_cfg_reset();
    test_zero_skip();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
